dem_giay_7seg: RTL and testbench

Seconds counter and 2-digit 7-segment display driver. It sits directly downstream of the slow-clock divider and consumes that divider's toggling output as its count tick. Rising edges of the tick advance a BCD count 00..59, up or down, with a wrap pulse. The BCD value is time-multiplexed onto a 2-digit common-anode display.

---
 rtl/dem_giay_7seg_pkg.sv | 47 ++++
 rtl/dem_giay_7seg_giai_ma_7seg.sv | 13 +
 rtl/dem_giay_7seg.sv | 132 +++++++++++++
 tb/tb_dem_giay_7seg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dem_giay_7seg_pkg.sv
// Shared constants for the seconds counter: BCD width, 7-segment patterns
// (active-low, gfedcba), digit-enable codes and the scan-slot type.
package dem_giay_7seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_t;

  // Codes 10..15 never occur in dv; they decode to a dark digit.
  function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/dem_giay_7seg_giai_ma_7seg.sv
// Combinational BCD digit to active-low 7-segment (gfedcba) decoder.
module giai_ma_7seg
  import dem_giay_7seg_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  always_comb begin
    seg = bcd_to_seg(digit);
  end

endmodule

// File: rtl/dem_giay_7seg.sv
// Seconds counter 00..MAX driven by rising edges of an asynchronous slow tick,
// with a wrap pulse and a 2-digit multiplexed common-anode display driver.
module dem_giay_7seg
  import dem_giay_7seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int MAX_TENS  = 5,
  parameter int MAX_UNITS = 9
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       en,
  input  logic       clr,
  input  logic       up,
  output logic [7:0] dv,
  output logic       tc,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [BCD_W-1:0] TENS_MAX   = BCD_W'(MAX_TENS);
  localparam logic [BCD_W-1:0] UNITS_MAX  = BCD_W'(MAX_UNITS);
  localparam logic [BCD_W-1:0] DIGIT_ZERO = BCD_W'(0);
  localparam logic [BCD_W-1:0] DIGIT_ONE  = BCD_W'(1);
  localparam logic [BCD_W-1:0] DIGIT_NINE = BCD_W'(9);

  logic             s1, s2, s3;
  logic [2:0]       vld;
  logic             ev;
  logic [BCD_W-1:0] tens, units;
  logic [7:0]       dv_step;
  logic             wrap;
  logic [CNT_W-1:0] scan_cnt;
  slot_t            slot;
  logic [BCD_W-1:0] scan_digit;
  logic [6:0]       seg_dec;

  // vld tracks which synchronizer stages hold real samples, so a tick that is
  // already high when reset releases is not mistaken for a rising edge.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      vld <= 3'b000;
    end else begin
      s1  <= tick_in;
      s2  <= s1;
      s3  <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  end

  assign ev    = s2 & ~s3 & vld[2];
  assign tens  = dv[7:4];
  assign units = dv[3:0];

  always_comb begin
    dv_step = dv;
    wrap    = 1'b0;
    if (up) begin
      if (tens == TENS_MAX && units == UNITS_MAX) begin
        dv_step = 8'h00;
        wrap    = 1'b1;
      end else if (units == DIGIT_NINE) begin
        dv_step = {tens + DIGIT_ONE, DIGIT_ZERO};
      end else begin
        dv_step = {tens, units + DIGIT_ONE};
      end
    end else begin
      if (dv == 8'h00) begin
        dv_step = {TENS_MAX, UNITS_MAX};
        wrap    = 1'b1;
      end else if (units == DIGIT_ZERO) begin
        dv_step = {tens - DIGIT_ONE, DIGIT_NINE};
      end else begin
        dv_step = {tens, units - DIGIT_ONE};
      end
    end
  end

  // clr outranks a coincident tick, which also suppresses any wrap pulse.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      dv <= 8'h00;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        dv <= 8'h00;
      end else if (ev && en) begin
        dv <= dv_step;
        tc <= wrap;
      end
    end
  end

  // The decoder looks at the digit of the slot about to become active.
  assign scan_digit = (slot == SLOT_UNITS) ? tens : units;

  giai_ma_7seg u_giai_ma (
    .digit (scan_digit),
    .seg   (seg_dec)
  );

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      slot     <= SLOT_UNITS;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        if (slot == SLOT_UNITS) begin
          slot <= SLOT_TENS;
          an   <= AN_TENS;
        end else begin
          slot <= SLOT_UNITS;
          an   <= AN_UNITS;
        end
        seg <= seg_dec;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dem_giay_7seg.sv
// Directed bench for dem_giay_7seg with SCAN_DIV=4: counting, wraps, pause,
// clear priority, display scan and reset behaviour.
module tb_dem_giay_7seg;

  logic       clki = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       up = 1'b1;
  logic [7:0] dv;
  logic       tc;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;

  always #5 clki = ~clki;

  dem_giay_7seg #(
    .SCAN_DIV  (4),
    .MAX_TENS  (5),
    .MAX_UNITS (9)
  ) dut (
    .clki    (clki),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .en      (en),
    .clr     (clr),
    .up      (up),
    .dv      (dv),
    .tc      (tc),
    .seg     (seg),
    .an      (an)
  );

  // One full tick: rise before edge k, dv updates at k+2; tc sampled then and one cycle later.
  task automatic tick(output logic tc_now, output logic tc_next);
    @(posedge clki); #2 tick_in = 1'b1;
    repeat (3) @(posedge clki);
    #1 tc_now = tc;
    @(posedge clki); #1 tc_next = tc;
    tick_in = 1'b0;
    repeat (3) @(posedge clki);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clki);
    #1;
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL reset_dv: got %h expected 00", dv); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", tc); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an: got %b expected 11", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    @(posedge clki); #1 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clki); #1;
      checks++; if (an !== 2'b11 || seg !== 7'h7F) begin
        errors++; $display("FAIL blank_cycle%0d: got an=%b seg=%h expected an=11 seg=7f", i, an, seg);
      end
    end
    @(posedge clki); #1;
    checks++; if (an !== 2'b01 || seg !== 7'h40) begin
      errors++; $display("FAIL first_slot_tens: got an=%b seg=%h expected an=01 seg=40", an, seg);
    end
    repeat (4) @(posedge clki); #1;
    checks++; if (an !== 2'b10 || seg !== 7'h40) begin
      errors++; $display("FAIL second_slot_units: got an=%b seg=%h expected an=10 seg=40", an, seg);
    end
    $display("reset done: dv=%h an=%b seg=%h", dv, an, seg);
  endtask

  task automatic test_count_up();
    logic [7:0] exp_old, exp_new;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_old = 8'(i - 1);
      exp_new = 8'(i);
      @(posedge clki); #2 tick_in = 1'b1;
      @(posedge clki);
      @(posedge clki); #1;
      checks++; if (dv !== exp_old) begin errors++; $display("FAIL latency_k1_%0d: got %h expected %h", i, dv, exp_old); end
      @(posedge clki); #1;
      checks++; if (dv !== exp_new) begin errors++; $display("FAIL latency_k2_%0d: got %h expected %h", i, dv, exp_new); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL count_up_tc_%0d: got %b expected 0", i, tc); end
      tick_in = 1'b0;
      repeat (4) @(posedge clki);
      $display("count_up tick %0d: dv=%h tc=%b", i, dv, tc);
    end
  endtask

  task automatic test_wrap_up();
    logic t0, t1;
    for (int i = 0; i < 55; i++) tick(t0, t1);
    checks++; if (dv !== 8'h58) begin errors++; $display("FAIL preload_58: got %h expected 58", dv); end
    tick(t0, t1);
    checks++; if (dv !== 8'h59 || t0 !== 1'b0) begin errors++; $display("FAIL up_to_59: got dv=%h tc=%b expected dv=59 tc=0", dv, t0); end
    tick(t0, t1);
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL wrap_up_dv: got %h expected 00", dv); end
    checks++; if (t0 !== 1'b1 || t1 !== 1'b0) begin errors++; $display("FAIL wrap_up_tc: got %b%b expected 10", t0, t1); end
    $display("wrap_up: dv=%h tc pulse=%b%b", dv, t0, t1);
  endtask

  task automatic test_wrap_down();
    logic t0, t1;
    up = 1'b0;
    tick(t0, t1);
    checks++; if (dv !== 8'h59) begin errors++; $display("FAIL wrap_down_dv: got %h expected 59", dv); end
    checks++; if (t0 !== 1'b1 || t1 !== 1'b0) begin errors++; $display("FAIL wrap_down_tc: got %b%b expected 10", t0, t1); end
    tick(t0, t1);
    checks++; if (dv !== 8'h58 || t0 !== 1'b0) begin errors++; $display("FAIL down_58: got dv=%h tc=%b expected dv=58 tc=0", dv, t0); end
    for (int i = 0; i < 9; i++) tick(t0, t1);
    checks++; if (dv !== 8'h49) begin errors++; $display("FAIL borrow_49: got %h expected 49", dv); end
    up = 1'b1;
    tick(t0, t1);
    checks++; if (dv !== 8'h50) begin errors++; $display("FAIL carry_50: got %h expected 50", dv); end
    $display("wrap_down: dv=%h", dv);
  endtask

  task automatic test_pause();
    logic t0, t1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick(t0, t1);
    checks++; if (dv !== 8'h50) begin errors++; $display("FAIL pause_hold: got %h expected 50", dv); end
    en = 1'b1;
    tick(t0, t1);
    checks++; if (dv !== 8'h51) begin errors++; $display("FAIL no_backlog: got %h expected 51", dv); end
    $display("pause: dv=%h", dv);
  endtask

  task automatic test_clr_wrap();
    logic t0, t1;
    for (int i = 0; i < 8; i++) tick(t0, t1);
    checks++; if (dv !== 8'h59) begin errors++; $display("FAIL preload_59: got %h expected 59", dv); end
    @(posedge clki); #2 tick_in = 1'b1;
    @(posedge clki);
    @(posedge clki); #2 clr = 1'b1;
    @(posedge clki); #1;
    checks++; if (dv !== 8'h00 || tc !== 1'b0) begin errors++; $display("FAIL clr_vs_wrap: got dv=%h tc=%b expected dv=00 tc=0", dv, tc); end
    clr = 1'b0;
    @(posedge clki); #1;
    checks++; if (tc !== 1'b0 || dv !== 8'h00) begin errors++; $display("FAIL clr_after: got dv=%h tc=%b expected dv=00 tc=0", dv, tc); end
    tick_in = 1'b0;
    repeat (4) @(posedge clki);
    $display("clr_wrap: dv=%h tc=%b", dv, tc);
  endtask

  task automatic test_scan_and_reset();
    logic t0, t1;
    logic [1:0] prev_an;
    bit found;
    for (int i = 0; i < 37; i++) tick(t0, t1);
    checks++; if (dv !== 8'h37) begin errors++; $display("FAIL preload_37: got %h expected 37", dv); end
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clki); #1;
      if (an === 2'b01 && prev_an !== 2'b01) found = 1'b1;
      prev_an = an;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_timeout: got an=%b expected transition to 01", an); end
    checks++; if (seg !== 7'h30) begin errors++; $display("FAIL scan_tens_seg: got %h expected 30", seg); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clki); #1;
      checks++; if (an !== 2'b01 || seg !== 7'h30) begin
        errors++; $display("FAIL scan_tens_hold%0d: got an=%b seg=%h expected an=01 seg=30", i, an, seg);
      end
    end
    @(posedge clki); #1;
    checks++; if (an !== 2'b10 || seg !== 7'h78) begin errors++; $display("FAIL scan_units: got an=%b seg=%h expected an=10 seg=78", an, seg); end
    repeat (4) @(posedge clki); #1;
    checks++; if (an !== 2'b01 || seg !== 7'h30) begin errors++; $display("FAIL scan_tens_again: got an=%b seg=%h expected an=01 seg=30", an, seg); end
    $display("scan: an=%b seg=%h dv=%h", an, seg, dv);
    @(posedge clki); #3 rst_n = 1'b0;
    #1;
    checks++; if (an !== 2'b11 || seg !== 7'h7F || dv !== 8'h00 || tc !== 1'b0) begin
      errors++; $display("FAIL async_reset: got an=%b seg=%h dv=%h tc=%b expected an=11 seg=7f dv=00 tc=0", an, seg, dv, tc);
    end
    tick_in = 1'b1;
    @(posedge clki); #1 rst_n = 1'b1;
    repeat (6) @(posedge clki); #1;
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL high_at_release: got %h expected 00", dv); end
    tick_in = 1'b0;
    repeat (3) @(posedge clki);
    tick(t0, t1);
    checks++; if (dv !== 8'h01) begin errors++; $display("FAIL fresh_tick: got %h expected 01", dv); end
    $display("reset mid-op: dv=%h an=%b seg=%h", dv, an, seg);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_pause();
    test_clr_wrap();
    test_scan_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
